// File: rtl/ram_bus_pkg.sv
// Shared types and helpers for the single-port, word-addressed RAM bus.
//
// Contents:
//   ram_req_t         one bus access: word address, write data, byte write mask
//   RAM_READ_LATENCY  cycles from read issue to read data on bus_data_r
//   OWNER_M0/M1       master encoding used for ownership/last-grant registers
//   is_read()         a zero byte mask means a read
package ram_bus_pkg;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data_w;
    logic [3:0]  mask_w;
  } ram_req_t;

  localparam int unsigned RAM_READ_LATENCY = 1;

  // Master indices; also the state encoding of the last-owner register.
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  function automatic logic is_read(logic [3:0] mask);
    return ~|mask;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One master's request/response channel into the RAM arbiter.
//
// Signals:
//   req     master requests an access; addr/data_w/mask_w held until gnt
//   addr    word address
//   data_w  write data
//   mask_w  byte write enables, 0 = read
//   gnt     access issued this cycle
//   rvalid  data_r carries this master's read data
//   data_r  read data (shared, qualified by rvalid)
//
// Modports: master (the requester), slave (the arbiter side).
interface ram_arbiter_if;

  logic        req;
  logic [29:0] addr;
  logic [31:0] data_w;
  logic [3:0]  mask_w;
  logic        gnt;
  logic        rvalid;
  logic [31:0] data_r;

  modport master (
    output req, addr, data_w, mask_w,
    input  gnt, rvalid, data_r
  );

  modport slave (
    input  req, addr, data_w, mask_w,
    output gnt, rvalid, data_r
  );

endinterface

// File: rtl/arb2_sel.sv
// Two-way grant selector with a burst limiter.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high; forces gnt low
//   req[1:0]   per-master request
//   gnt[1:0]   per-master grant, combinational, at most one bit set
//
// Parameter MAX_BURST (1..15): consecutive contested grants one master may
// take before the waiting peer is served.
//
// Build option RAM_ARB_RR_EN: when defined, contested cycles alternate
// strictly (the master that was not granted last wins) and the burst counter
// is held at zero. Undefined: m0 has fixed priority, limited by MAX_BURST.
module arb2_sel
  import ram_bus_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       both;
  logic       any;
  logic       winner;

  always_comb begin
    both   = req[0] & req[1];
    any    = req[0] | req[1];
    winner = req[0] ? OWNER_M0 : OWNER_M1;
    if (both) begin
`ifdef RAM_ARB_RR_EN
      winner = ~last_q;
`else
      // A saturated counter means the last owner used up its burst.
      winner = (cnt_q == MaxBurst) ? ~last_q : OWNER_M0;
`endif
    end
  end

  assign gnt = (any && !reset) ? ((winner == OWNER_M1) ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (|gnt) begin
      last_d = winner;
`ifdef RAM_ARB_RR_EN
      cnt_d = 4'd0;
`else
      // Only contested repeat grants extend a burst; anything else restarts it.
      if (both && (winner == last_q)) begin
        cnt_d = (cnt_q >= MaxBurst) ? MaxBurst : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= OWNER_M1;
      cnt_q  <= 4'd0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter sharing one single-port word-addressed RAM bus.
// Typical use: instruction fetch on m0, load/store on m1.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   m0, m1              master channels (ram_arbiter_if.slave)
//   bus_addr/_data_w/_mask_w  access issued to the RAM this cycle
//   bus_data_r          RAM read data, valid one cycle after a read issue
//
// At most one access is issued per cycle. The granted master's fields drive
// the bus in the grant cycle; idle cycles present an all-zero read whose data
// is ignored. Read ownership is registered so the one-cycle-latency data can
// be flagged to the right master.
//
// Build option RAM_ARB_RR_EN selects round-robin arbitration (see arb2_sel).
module ram_arbiter
  import ram_bus_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  output logic [29:0]   bus_addr,
  output logic [31:0]   bus_data_w,
  output logic [3:0]    bus_mask_w,
  input  logic [31:0]   bus_data_r
);

  logic [1:0] req;
  logic [1:0] gnt;
  ram_req_t   m0_fields;
  ram_req_t   m1_fields;
  ram_req_t   bus_req;

  logic resp_valid_q, resp_valid_d;
  logic resp_owner_q, resp_owner_d;

  assign req = {m1.req, m0.req};

  arb2_sel #(
    .MAX_BURST (MAX_BURST)
  ) u_sel (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  assign m0_fields = {m0.addr, m0.data_w, m0.mask_w};
  assign m1_fields = {m1.addr, m1.data_w, m1.mask_w};

  always_comb begin
    bus_req = '0;
    unique case (gnt)
      2'b01:   bus_req = m0_fields;
      2'b10:   bus_req = m1_fields;
      default: bus_req = '0;
    endcase
  end

  assign bus_addr   = bus_req.addr;
  assign bus_data_w = bus_req.data_w;
  assign bus_mask_w = bus_req.mask_w;

  // Writes complete at grant; only granted reads expect data next cycle.
  always_comb begin
    resp_valid_d = (|gnt) & is_read(bus_req.mask_w);
    resp_owner_d = (|gnt) ? gnt[1] : resp_owner_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWNER_M0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Reset in the response cycle drops the read; the master re-requests.
  assign m0.rvalid = resp_valid_q & ~reset & (resp_owner_q == OWNER_M0);
  assign m1.rvalid = resp_valid_q & ~reset & (resp_owner_q == OWNER_M1);

  // Read data is shared and unqualified; rvalid says whose it is.
  assign m0.data_r = bus_data_r;
  assign m1.data_r = bus_data_r;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import ram_bus_pkg::*;

  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned MemWords  = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ram_arbiter_if m0_if ();
  ram_arbiter_if m1_if ();

  logic [29:0] bus_addr;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic [31:0] bus_data_r;

  ram_arbiter #(
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .m0         (m0_if),
    .m1         (m1_if),
    .bus_addr   (bus_addr),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w),
    .bus_data_r (bus_data_r)
  );

  // ---------------- RAM environment ----------------
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [31:0] ram [MemWords];
  always @(posedge clock) begin
    bus_data_r <= ram[bus_addr[5:0]];
    if (bus_mask_w != 4'h0) ram[bus_addr[5:0]] <= merge(ram[bus_addr[5:0]], bus_data_w, bus_mask_w);
  end

  // ---------------- bench assertions ----------------
  initial assert (MAX_BURST >= 1 && MAX_BURST <= 15)
    else $fatal(1, "FAIL max_burst_range: got %0d, required 1..15", MAX_BURST);

  a_m0_hold: assert property (@(posedge clock) disable iff (reset)
    (m0_if.req && !m0_if.gnt) |=> (m0_if.req && $stable(m0_if.addr) &&
                                   $stable(m0_if.data_w) && $stable(m0_if.mask_w)));
  a_m1_hold: assert property (@(posedge clock) disable iff (reset)
    (m1_if.req && !m1_if.gnt) |=> (m1_if.req && $stable(m1_if.addr) &&
                                   $stable(m1_if.data_w) && $stable(m1_if.mask_w)));

  // ---------------- stimulus / model state ----------------
  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  typedef struct {
    int          due;
    bit          owner;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit owner;
    bit contested;
  } grant_t;

  txn_t        q0[$], q1[$];
  txn_t        cur0, cur1;
  bit          busy0, busy1;
  resp_t       sb[$];
  grant_t      hist[$];
  bit          gseq[$];
  bit          log_en, rand_en, rst_drv;
  logic [31:0] ref_mem [MemWords];
  int          cyc, n_vec, n_bad;
  resp_t       mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t rand_txn(bit force_read);
    txn_t t;
    t.addr = 30'($urandom_range(0, 31));
    t.data = $urandom;
    t.mask = (force_read || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    return t;
  endfunction

  // Length of the current owner's streak: trailing grants to the same
  // master, where an uncontested grant starts a fresh streak of one.
  function automatic int run_len();
    int r;
    bit own;
    r   = 0;
    own = hist[hist.size()-1].owner;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].owner != own) break;
      r++;
      if (!hist[i].contested) break;
    end
    return r;
  endfunction

  // Winner when both masters request.
  function automatic bit model_winner();
    bit last_owner;
    int run;
    if (hist.size() == 0) begin
      last_owner = 1'b1;
      run        = 0;
    end else begin
      last_owner = hist[hist.size()-1].owner;
      run        = run_len();
    end
`ifdef RAM_ARB_RR_EN
    return !last_owner;
`else
    return (run >= int'(MAX_BURST)) ? !last_owner : 1'b0;
`endif
  endfunction

  task automatic check_cycle();
    bit       r0, r1, w;
    bit [1:0] exp_g;
    txn_t     t;
    r0    = busy0;
    r1    = busy1;
    w     = 1'b0;
    exp_g = 2'b00;
    if (!reset && (r0 || r1)) begin
      w     = (r0 && r1) ? model_winner() : r1;
      exp_g = w ? 2'b10 : 2'b01;
    end
    t = w ? cur1 : cur0;
    check("gnt", 64'({m1_if.gnt, m0_if.gnt}), 64'(exp_g));
    check("bus_addr",   64'(bus_addr),   (exp_g != 0) ? 64'(t.addr) : 64'd0);
    check("bus_data_w", 64'(bus_data_w), (exp_g != 0) ? 64'(t.data) : 64'd0);
    check("bus_mask_w", 64'(bus_mask_w), (exp_g != 0) ? 64'(t.mask) : 64'd0);
    if (reset) begin
      hist.delete();
    end else if (exp_g != 0) begin
      hist.push_back('{owner: w, contested: r0 && r1});
      if (hist.size() > 24) void'(hist.pop_front());
      if (log_en) gseq.push_back(w);
      if (t.mask == 4'h0) begin
        sb.push_back('{due: cyc + int'(RAM_READ_LATENCY), owner: w, data: ref_mem[t.addr[5:0]]});
      end else begin
        ref_mem[t.addr[5:0]] = merge(ref_mem[t.addr[5:0]], t.data, t.mask);
      end
    end
  endtask

  task automatic drive_if();
    m0_if.req    = busy0;
    m0_if.addr   = cur0.addr;
    m0_if.data_w = cur0.data;
    m0_if.mask_w = cur0.mask;
    m1_if.req    = busy1;
    m1_if.addr   = cur1.addr;
    m1_if.data_w = cur1.data;
    m1_if.mask_w = cur1.mask;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    reset = rst_drv;
    if (rand_en) begin
      if (!busy0 && q0.size() == 0 && $urandom_range(0, 9) < 5) q0.push_back(rand_txn(1'b0));
      if (!busy1 && q1.size() == 0 && $urandom_range(0, 9) < 5) q1.push_back(rand_txn(1'b0));
    end
    if (!busy0 && q0.size() != 0) begin cur0 = q0.pop_front(); busy0 = 1'b1; end
    if (!busy1 && q1.size() != 0) begin cur1 = q1.pop_front(); busy1 = 1'b1; end
    drive_if();
    @(negedge clock);
    check_cycle();
    if (m0_if.gnt) busy0 = 1'b0;
    if (m1_if.gnt) busy1 = 1'b0;
    cyc++;
  endtask

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    while ((busy0 || busy1 || q0.size() != 0 || q1.size() != 0) && n < limit) begin
      step();
      n++;
    end
    check("drain_pending", 64'(int'(busy0) + int'(busy1) + q0.size() + q1.size()), 64'd0);
    step();
    step();
  endtask

  // ---------------- response monitor ----------------
  initial begin
    logic [1:0]  exp_rv;
    logic [31:0] exp_d;
    forever begin
      @(posedge clock);
      #2;
      exp_rv = 2'b00;
      exp_d  = 32'h0;
      while (sb.size() != 0 && sb[0].due < cyc) void'(sb.pop_front());
      if (sb.size() != 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        if (!reset) begin
          exp_rv = mon_e.owner ? 2'b10 : 2'b01;
          exp_d  = mon_e.data;
        end
      end
      check("rvalid", 64'({m1_if.rvalid, m0_if.rvalid}), 64'(exp_rv));
      if (exp_rv != 2'b00)
        check("data_r", 64'(mon_e.owner ? m1_if.data_r : m0_if.data_r), 64'(exp_d));
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < int'(MemWords); i++) begin
      ram[i]     = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    busy0 = 1'b0; busy1 = 1'b0;
    cur0 = '{addr: '0, data: '0, mask: '0};
    cur1 = '{addr: '0, data: '0, mask: '0};
    drive_if();
    rst_drv = 1'b1; log_en = 1'b0; rand_en = 1'b0;
    cyc = 0; n_vec = 0; n_bad = 0;

    // m0 read of 0x10 held through reset: no grant until reset drops.
    q0.push_back('{addr: 30'h10, data: 32'h0, mask: 4'h0});
    repeat (3) step();
    rst_drv = 1'b0;
    run_until_idle(10);

    // m1 full-word write then read-back at address 5.
    q1.push_back('{addr: 30'd5, data: 32'hDEADBEEF, mask: 4'hF});
    q1.push_back('{addr: 30'd5, data: 32'h0, mask: 4'h0});
    run_until_idle(10);

    // Both masters hold reads continuously from a fresh reset.
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    log_en  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      q0.push_back(rand_txn(1'b1));
      q1.push_back(rand_txn(1'b1));
    end
    run_until_idle(40);
    log_en = 1'b0;
    check("grant_seq_len", 64'(gseq.size() >= 10), 64'd1);
    for (int i = 0; i < 10 && i < gseq.size(); i++) begin
`ifdef RAM_ARB_RR_EN
      check("grant_order", 64'(gseq[i]), 64'(i % 2));
`else
      check("grant_order", 64'(gseq[i]), 64'((i % (int'(MAX_BURST) + 1)) == int'(MAX_BURST)));
`endif
    end

    // Read granted, reset in the response cycle: response dropped.
    q0.push_back('{addr: 30'd3, data: 32'h0, mask: 4'h0});
    step();
    rst_drv = 1'b1;
    q1.push_back('{addr: 30'd4, data: 32'h0, mask: 4'h0});
    step();
    step();
    rst_drv = 1'b0;
    run_until_idle(10);

    // Half-word writes from m0 racing reads of the same word from m1.
    for (int i = 0; i < 8; i++) begin
      q0.push_back('{addr: 30'd7, data: $urandom, mask: 4'h3});
      q1.push_back('{addr: 30'd7, data: 32'h0, mask: 4'h0});
    end
    run_until_idle(40);

    // Random traffic with occasional resets.
    rand_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rst_drv = ($urandom_range(0, 99) < 2);
      step();
    end
    rand_en = 1'b0;
    rst_drv = 1'b0;
    run_until_idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter sharing one single-port word-addressed RAM bus.
- Typical pairing: instruction fetch as m0, load/store as m1.
- Issues at most one access per cycle to the RAM. Tracks which master owns the in-flight read and routes the one-cycle-latency read data back to it.
- Fairness: a burst limiter caps consecutive grants to one master while the other waits.

Parameters:
- MAX_BURST, 4: max consecutive grants to one master while the other has req asserted; range 1..15.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- m0_req  in  1  m0 requests an access; m0_addr/m0_data_w/m0_mask_w must stay stable until m0_gnt
- m0_addr  in  30  word address
- m0_data_w  in  32  write data
- m0_mask_w  in  4  byte write enables; 0 = read
- m0_gnt  out  1  access issued this cycle (combinational)
- m0_rvalid  out  1  m0_data_r valid (registered, one cycle after a granted read)
- m0_data_r  out  32  read data
- m1_*  (same seven ports as m0, for master 1)
- bus_addr  out  30  to RAM
- bus_data_w  out  32  to RAM
- bus_mask_w  out  4  to RAM
- bus_data_r  in  32  from RAM; valid one cycle after a read issue, undefined otherwise

Behaviour:
- Grant is combinational from req and arbitration state; at most one of m0_gnt/m1_gnt is high per cycle.
- No request, or reset high: both gnt = 0, bus_mask_w = 0, bus_addr = 0, bus_data_w = 0. This is a harmless idle read; its data is discarded.
- Granted master's addr/data/mask drive the bus in the same cycle. The RAM commits a write that cycle, or returns read data next cycle.
- A write completes at gnt and produces no rvalid.
- Response tracking: registered resp_valid, resp_owner.
  - resp_valid <= granted & (granted mask == 0).
  - mX_rvalid = resp_valid & (resp_owner == X).
  - m0_data_r = m1_data_r = bus_data_r, unqualified; masters use rvalid.
- Requests may be issued back-to-back every cycle. A read response in cycle N+1 and a new grant in cycle N+1 do not conflict.
- Arbitration when only one req is high: grant it.
- Arbitration when both are high:
  - Default: m0 wins (fixed priority), subject to the burst limiter.
  - Burst counter cnt (4 bits) and last-owner register last.
  - When both requested and the winner == last: cnt <= cnt + 1, saturating at MAX_BURST.
  - When the winner differs from last: cnt <= 1.
  - If cnt == MAX_BURST and the other master is requesting, the other master wins this cycle.
  - When the grant goes to a master whose peer is not requesting: cnt <= 1.
  - No grant: cnt and last hold.
- Reset values: last = 1, cnt = 0, resp_valid = 0, resp_owner = 0. All rvalid are 0 in the cycle after reset.
- Reset asserted the cycle after a read grant: resp_valid clears, the response is dropped, and the master must re-request.
- Address range: no decode here; the RAM handles aliasing.
- Assertions (bench):
  - mX_req is not withdrawn before gnt.
  - Fields are stable while req is high and gnt is low.
  - MAX_BURST is in 1..15.

Optional Feature:
- RAM_ARB_RR_EN
- Defined: pure round-robin. When both masters request, the master != last wins. MAX_BURST and cnt are ignored; cnt stays 0.
- Undefined: fixed priority with the burst limiter as above.

Decomposition:
- Shared package ram_bus_pkg:
  - Typedef ram_req_t {addr[29:0], data_w[31:0], mask_w[3:0]}.
  - Constant RAM_READ_LATENCY = 1.
  - Function is_read(mask) = ~|mask.
- One sub-module, arb2_sel: the 2-way grant/burst-counter FSM with inputs req[1:0] and outputs gnt[1:0].
- Top level handles the bus mux and response tracking.

Test Plan:
- m0 reads addr 0x10 alone → m0_gnt same cycle, bus_addr = 0x10, bus_mask_w = 0; next cycle m0_rvalid = 1 with RAM content; m1_rvalid = 0.
- m1 writes 0xDEADBEEF, mask 0xF, to addr 5 with m0 idle → m1_gnt = 1, no rvalid. Then m1 reads addr 5 → m1_data_r = 0xDEADBEEF, m1_rvalid = 1.
- Both masters hold read reqs continuously, MAX_BURST = 4, RAM_ARB_RR_EN undefined → grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1… Each rvalid goes to the owner of the prior-cycle read.
- Same stimulus with RAM_ARB_RR_EN defined → m0,m1,m0,m1…, m0 first after reset.
- m0 read granted at cycle N, reset asserted at N+1 → no rvalid at N+1 or N+2; all gnt = 0 during reset.
- m0 write mask 0x3 and m1 read interleaved every cycle → byte lanes 0-1 updated only. Reads never return rvalid to the writer. No cycle with both gnt high.
